// File: rtl/pixel_window5_pkg.sv
// Shared definitions for the binary edge-detector front end: window geometry
// and the window-stage FSM encoding.
package pixel_window5_pkg;

  localparam int WIN_W = 5;
  localparam int WIN_C = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH1 = 2'd1,
    FLUSH2 = 2'd2
  } state_t;

  // New sample enters at the top, oldest falls off bit 0.
  function automatic logic [WIN_W-1:0] shift_in(input logic [WIN_W-1:0] sr, input logic b);
    return {b, sr[WIN_W-1:1]};
  endfunction

endpackage

// File: rtl/pixel_window5.sv
// Streams 1-bit pixels in raster order and emits the 5-wide horizontal window
// centred on every pixel, border-padding and flushing the last two per line.
module pixel_window5
  import pixel_window5_pkg::*;
#(
  parameter int   COL_W = 10,
  parameter logic PAD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_in,
  input  logic             pix_valid,
  input  logic             line_end,
  output logic             in_ready,
  output logic [WIN_W-1:0] win_out,
  output logic             win_valid,
  output logic             win_last,
  output logic [COL_W-1:0] win_col
);

  state_t           state;
  logic [WIN_W-1:0] sr;
  logic [1:0]       fill;
  logic [COL_W-1:0] cnt;
  logic [WIN_W-1:0] sr_nxt;

  assign in_ready = (state == RUN);
  assign sr_nxt   = shift_in(sr, (state == RUN) ? pix_in : PAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      sr        <= {WIN_W{PAD}};
      fill      <= 2'd0;
      cnt       <= '0;
      win_out   <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_col   <= '0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      case (state)
        RUN: begin
          if (pix_valid) begin
            sr  <= sr_nxt;
            cnt <= cnt + COL_W'(1);
            if (fill != 2'd2) fill <= fill + 2'd1;
            // Two pixels of look-ahead in hand: centre column is two behind.
            if (fill == 2'd2) begin
              win_out   <= sr_nxt;
              win_col   <= cnt - COL_W'(2);
              win_valid <= 1'b1;
            end
            if (line_end) state <= FLUSH1;
          end
        end
        FLUSH1: begin
          sr <= sr_nxt;
          // A line of one pixel has no column n-2 to emit.
          if (fill == 2'd2) begin
            win_out   <= sr_nxt;
            win_col   <= cnt - COL_W'(2);
            win_valid <= 1'b1;
          end
          state <= FLUSH2;
        end
        FLUSH2: begin
          sr        <= {WIN_W{PAD}};
          fill      <= 2'd0;
          cnt       <= '0;
          win_out   <= sr_nxt;
          win_col   <= cnt - COL_W'(1);
          win_valid <= 1'b1;
          win_last  <= 1'b1;
          state     <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_window5.sv
// Drives two instances (PAD=0/COL_W=10 and PAD=1/COL_W=3) with the same pixel
// stream and checks every cycle against a line-buffer reference model.
module tb_pixel_window5;
  import pixel_window5_pkg::*;

  logic clk = 1'b0;
  logic rst, pix_in, pix_valid, line_end;
  logic rdy0, rdy1, v0, v1, l0, l1;
  logic [WIN_W-1:0] w0, w1;
  logic [9:0] c0;
  logic [2:0] c1;

  always #5 clk = ~clk;

  pixel_window5 #(.COL_W(10), .PAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .line_end(line_end),
    .in_ready(rdy0), .win_out(w0), .win_valid(v0), .win_last(l0), .win_col(c0));

  pixel_window5 #(.COL_W(3), .PAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .line_end(line_end),
    .in_ready(rdy1), .win_out(w1), .win_valid(v1), .win_last(l1), .win_col(c1));

  typedef struct {
    int         cyc;
    int         col;
    logic [4:0] wa;
    logic [4:0] wb;
    logic       last;
  } exp_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   flush    = 0;
  bit   junk_valid = 1'b0;
  logic line_q[$];
  exp_t expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Window centred on column c of the line held so far, padded outside it.
  function automatic logic [4:0] win_at(input logic pad, input int c);
    logic [4:0] w;
    for (int i = 0; i < 5; i++) begin
      int idx;
      idx = c - 2 + i;
      w[i] = (idx >= 0 && idx < line_q.size()) ? line_q[idx] : pad;
    end
    return w;
  endfunction

  task automatic push_win(input int at, input int col, input logic last);
    exp_t e;
    e.cyc = at; e.col = col; e.last = last;
    e.wa = win_at(1'b0, col);
    e.wb = win_at(1'b1, col);
    expq.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (expq.size() != 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      chk("win_valid0", 32'(v0), 32'(1));
      chk("win_out0",   32'(w0), 32'(e.wa));
      chk("win_col0",   32'(c0), 32'(e.col % 1024));
      chk("win_last0",  32'(l0), 32'(e.last));
      chk("win_valid1", 32'(v1), 32'(1));
      chk("win_out1",   32'(w1), 32'(e.wb));
      chk("win_col1",   32'(c1), 32'(e.col % 8));
      chk("win_last1",  32'(l1), 32'(e.last));
    end else begin
      chk("idle_valid0", 32'(v0), 32'(0));
      chk("idle_valid1", 32'(v1), 32'(0));
    end
  endtask

  // One clock: drive inputs, update the model, then sample 1 time unit after the edge.
  task automatic step(input logic pv, input logic px, input logic le);
    int n;
    pix_valid = pv; pix_in = px; line_end = le;
    chk("in_ready0", 32'(rdy0), 32'(flush == 0));
    chk("in_ready1", 32'(rdy1), 32'(flush == 0));
    if (flush == 0 && pv) begin
      line_q.push_back(px);
      n = line_q.size();
      if (n >= 3) push_win(cyc + 1, n - 3, 1'b0);
      if (le) begin
        if (n >= 2) push_win(cyc + 2, n - 2, 1'b0);
        push_win(cyc + 3, n - 1, 1'b1);
        line_q.delete();
        flush = 2;
      end
    end else if (flush > 0) begin
      flush--;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Offer a pixel, first riding out any flush (optionally with pix_valid held high).
  task automatic offer(input logic px, input logic le);
    int guard = 0;
    while (flush != 0 && guard < 4) begin
      step(junk_valid, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      guard++;
    end
    step(1'b1, px, le);
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; line_end = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid0", 32'(v0), 32'(0));
    chk("rst_out0",   32'(w0), 32'(0));
    chk("rst_col0",   32'(c0), 32'(0));
    chk("rst_last0",  32'(l0), 32'(0));
    chk("rst_ready0", 32'(rdy0), 32'(1));
    chk("rst_valid1", 32'(v1), 32'(0));
    chk("rst_out1",   32'(w1), 32'(0));
    chk("rst_ready1", 32'(rdy1), 32'(1));
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    line_q.delete();
    expq.delete();
    flush = 0;
  endtask

  initial begin
    bit la [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int len;
    rst = 1'b0; pix_valid = 1'b0; pix_in = 1'b0; line_end = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("init_valid0", 32'(v0), 32'(0));
    chk("init_out0",   32'(w0), 32'(0));
    chk("init_col0",   32'(c0), 32'(0));
    chk("init_last0",  32'(l0), 32'(0));
    chk("init_ready0", 32'(rdy0), 32'(1));
    chk("init_out1",   32'(w1), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Six-pixel line, continuous valid.
    for (int i = 0; i < 6; i++) offer(la[i], i == 5);
    // Valid held high through flushes: single 1, then 1,1, then single 0.
    junk_valid = 1'b1;
    offer(1'b1, 1'b1);
    offer(1'b1, 1'b0);
    offer(1'b1, 1'b1);
    offer(1'b0, 1'b1);
    offer(1'b1, 1'b0);
    offer(1'b0, 1'b1);
    idle(4);
    junk_valid = 1'b0;

    // Reset after 4 pixels of a line, then a fresh 0,1,0 line.
    offer(1'b1, 1'b0); offer(1'b0, 1'b0); offer(1'b1, 1'b0); offer(1'b1, 1'b0);
    do_reset();
    offer(1'b0, 1'b0); offer(1'b1, 1'b0); offer(1'b0, 1'b1);
    idle(4);

    // Reset in the middle of a flush.
    offer(1'b1, 1'b0); offer(1'b1, 1'b0); offer(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    do_reset();
    idle(3);
    offer(1'b1, 1'b1);
    idle(3);

    // Random lines with gaps; lengths exceed 8 so the COL_W=3 instance wraps.
    for (int ln = 0; ln < 40; ln++) begin
      len = $urandom_range(1, 20);
      junk_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        offer(1'($urandom_range(0, 1)), i == len - 1);
      end
    end
    idle(5);
    chk("drain", 32'(expq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
